bus_arb_2: RTL and testbench

BUS_ARB_2 -- requirements
Module: bus_arb_2

---
 rtl/bus_arb_2.sv | 228 ++++++++++++++++++++++
 tb/tb_bus_arb_2.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb_2.sv
// bus_arb_2 -- two-requester round-robin arbiter onto a single-outstanding sub-bus.
//
// A granted transaction runs IDLE -> WR -> DONE for writes, or
// IDLE -> RD -> [RD_WAIT]* -> DONE for reads.  Every output is registered.
// A read that sees no bus_rd_ack within TIMEOUT wait cycles completes with
// a 32'hDEADBEEF pattern and the error flag set.
//
// Parameters
//   ADDR_W   bus address width
//   DATA_W   bus data width
//   TIMEOUT  maximum RD_WAIT cycles before error completion
//
// Ports
//   bus_clk, bus_reset_l                  clock, asynchronous active-low reset
//   mN_req/we/addr/wdata/be   (in)        requester N transaction, held until mN_ack
//   mN_ack/rdata/err          (out)       one-cycle completion pulse, read data, error
//   bus_rd_req/bus_wr_req     (out)       one-cycle sub-bus strobes
//   bus_addr/bus_wr_data/bus_be (out)     latched transaction fields, held until next grant
//   bus_rd_ack/bus_rd_data    (in)        sub-bus read response

module bus_arb_2 #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              bus_clk,
  input  logic              bus_reset_l,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_be,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_be,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,

  output logic              bus_rd_req,
  output logic              bus_wr_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  output logic [3:0]        bus_be,
  input  logic              bus_rd_ack,
  input  logic [DATA_W-1:0] bus_rd_data
);

  // Wide enough to count up to TIMEOUT without wrapping.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX        = CNT_W'(TIMEOUT);
  localparam logic [31:0]       TIMEOUT_DATA32 = 32'hDEADBEEF;
  localparam logic [DATA_W-1:0] TIMEOUT_DATA   = DATA_W'(TIMEOUT_DATA32);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic              last_grant, last_grant_nxt;
  logic              grant, grant_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic              bus_rd_req_nxt, bus_wr_req_nxt;
  logic [ADDR_W-1:0] bus_addr_nxt;
  logic [DATA_W-1:0] bus_wr_data_nxt;
  logic [3:0]        bus_be_nxt;
  logic              m0_ack_nxt, m1_ack_nxt;
  logic [DATA_W-1:0] m0_rdata_nxt, m1_rdata_nxt;
  logic              m0_err_nxt, m1_err_nxt;

  logic              sel;
  logic              sel_we;
  logic              complete;
  logic              load_rdata;
  logic [DATA_W-1:0] comp_data;
  logic              comp_err;

  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      cnt         <= '0;
      bus_rd_req  <= 1'b0;
      bus_wr_req  <= 1'b0;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      bus_be      <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      grant       <= grant_nxt;
      cnt         <= cnt_nxt;
      bus_rd_req  <= bus_rd_req_nxt;
      bus_wr_req  <= bus_wr_req_nxt;
      bus_addr    <= bus_addr_nxt;
      bus_wr_data <= bus_wr_data_nxt;
      bus_be      <= bus_be_nxt;
      m0_ack      <= m0_ack_nxt;
      m1_ack      <= m1_ack_nxt;
      m0_rdata    <= m0_rdata_nxt;
      m1_rdata    <= m1_rdata_nxt;
      m0_err      <= m0_err_nxt;
      m1_err      <= m1_err_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    grant_nxt       = grant;
    cnt_nxt         = cnt;
    bus_rd_req_nxt  = 1'b0;
    bus_wr_req_nxt  = 1'b0;
    bus_addr_nxt    = bus_addr;
    bus_wr_data_nxt = bus_wr_data;
    bus_be_nxt      = bus_be;
    m0_ack_nxt      = 1'b0;
    m1_ack_nxt      = 1'b0;
    m0_rdata_nxt    = m0_rdata;
    m1_rdata_nxt    = m1_rdata;
    m0_err_nxt      = m0_err;
    m1_err_nxt      = m1_err;
    sel             = 1'b0;
    sel_we          = 1'b0;
    complete        = 1'b0;
    load_rdata      = 1'b0;
    comp_data       = '0;
    comp_err        = 1'b0;

    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the requester not granted last wins.
          sel             = (m0_req && m1_req) ? ~last_grant : m1_req;
          sel_we          = sel ? m1_we : m0_we;
          grant_nxt       = sel;
          last_grant_nxt  = sel;
          bus_addr_nxt    = sel ? m1_addr  : m0_addr;
          bus_wr_data_nxt = sel ? m1_wdata : m0_wdata;
          bus_be_nxt      = sel ? m1_be    : m0_be;
          if (sel_we) begin
            state_nxt      = WR;
            bus_wr_req_nxt = 1'b1;
          end else begin
            state_nxt      = RD;
            bus_rd_req_nxt = 1'b1;
          end
        end
      end

      WR: begin
        complete = 1'b1;
      end

      RD: begin
        cnt_nxt = '0;
        if (bus_rd_ack) begin
          complete   = 1'b1;
          load_rdata = 1'b1;
          comp_data  = bus_rd_data;
        end else begin
          state_nxt = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (bus_rd_ack) begin
          complete   = 1'b1;
          load_rdata = 1'b1;
          comp_data  = bus_rd_data;
        end else if (cnt == CNT_MAX) begin
          complete   = 1'b1;
          load_rdata = 1'b1;
          comp_data  = TIMEOUT_DATA;
          comp_err   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Only the granted requester's ack/rdata/err move on completion.
    if (complete) begin
      state_nxt = DONE;
      if (!grant) begin
        m0_ack_nxt = 1'b1;
        m0_err_nxt = comp_err;
        if (load_rdata) begin
          m0_rdata_nxt = comp_data;
        end
      end else begin
        m1_ack_nxt = 1'b1;
        m1_err_nxt = comp_err;
        if (load_rdata) begin
          m1_rdata_nxt = comp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arb_2.sv
// tb_bus_arb_2 -- directed self-checking bench for bus_arb_2 (TIMEOUT=4).
//
// Inputs change 1 time unit after each rising edge and outputs are sampled
// at that same point, so every check sees the state registered by the edge.

module tb_bus_arb_2;

  logic        bus_clk;
  logic        bus_reset_l;
  logic        m0_req, m0_we;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_be;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_be;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdata;
  logic        bus_rd_req, bus_wr_req;
  logic [31:0] bus_addr, bus_wr_data;
  logic [3:0]  bus_be;
  logic        bus_rd_ack;
  logic [31:0] bus_rd_data;

  int vectors;
  int miscompares;

  bus_arb_2 #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .bus_clk     (bus_clk),
    .bus_reset_l (bus_reset_l),
    .m0_req      (m0_req),
    .m0_we       (m0_we),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_be       (m0_be),
    .m0_ack      (m0_ack),
    .m0_rdata    (m0_rdata),
    .m0_err      (m0_err),
    .m1_req      (m1_req),
    .m1_we       (m1_we),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_be       (m1_be),
    .m1_ack      (m1_ack),
    .m1_rdata    (m1_rdata),
    .m1_err      (m1_err),
    .bus_rd_req  (bus_rd_req),
    .bus_wr_req  (bus_wr_req),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_be      (bus_be),
    .bus_rd_ack  (bus_rd_ack),
    .bus_rd_data (bus_rd_data)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic applyStimulus(input bit m, input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be);
    if (!m) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_wr_req"}, bus_wr_req, 1'b0);
    checkOutput({tag, "_rd_req"}, bus_rd_req, 1'b0);
    checkOutput({tag, "_m0_ack"}, m0_ack, 1'b0);
    checkOutput({tag, "_m1_ack"}, m1_ack, 1'b0);
  endtask

  initial begin
    logic exp_m;
    vectors     = 0;
    miscompares = 0;
    bus_reset_l = 1'b0;
    bus_rd_ack  = 1'b0;
    bus_rd_data = '0;
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 4'h0);

    // Reset state
    tick();
    tick();
    checkIdleOutputs("rst");
    checkOutput("rst_addr", bus_addr, 32'h0);
    checkOutput("rst_wdata", bus_wr_data, 32'h0);
    checkOutput("rst_be", bus_be, 4'h0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'h0);
    checkOutput("rst_m1_err", m1_err, 1'b0);
    bus_reset_l = 1'b1;
    tick();
    checkIdleOutputs("post_rst");

    // Single write from m0
    applyStimulus(0, 1, 1, 32'h100, 32'hA5A5A5A5, 4'hF);
    tick();
    checkOutput("wr_strobe", bus_wr_req, 1'b1);
    checkOutput("wr_rd_req", bus_rd_req, 1'b0);
    checkOutput("wr_addr", bus_addr, 32'h100);
    checkOutput("wr_data", bus_wr_data, 32'hA5A5A5A5);
    checkOutput("wr_be", bus_be, 4'hF);
    checkOutput("wr_early_ack", m0_ack, 1'b0);
    tick();
    checkOutput("wr_strobe_off", bus_wr_req, 1'b0);
    checkOutput("wr_m0_ack", m0_ack, 1'b1);
    checkOutput("wr_m0_err", m0_err, 1'b0);
    checkOutput("wr_m1_ack", m1_ack, 1'b0);
    tick();
    applyStimulus(0, 0, 1, 32'h100, 32'hA5A5A5A5, 4'hF);
    checkIdleOutputs("wr_after_done");
    tick();
    checkIdleOutputs("wr_no_reissue");
    checkOutput("wr_addr_hold", bus_addr, 32'h100);

    // Read from m1, response 3 cycles after the strobe
    applyStimulus(1, 1, 0, 32'h204, 32'h11111111, 4'h3);
    tick();
    checkOutput("rd_strobe", bus_rd_req, 1'b1);
    checkOutput("rd_wr_req", bus_wr_req, 1'b0);
    checkOutput("rd_addr", bus_addr, 32'h204);
    checkOutput("rd_be", bus_be, 4'h3);
    checkOutput("rd_wdata_latch", bus_wr_data, 32'h11111111);
    tick();
    checkOutput("rd_strobe_off", bus_rd_req, 1'b0);
    tick();
    checkOutput("rd_wait_ack", m1_ack, 1'b0);
    tick();
    bus_rd_ack  = 1'b1;
    bus_rd_data = 32'h12345678;
    checkOutput("rd_wait_ack2", m1_ack, 1'b0);
    tick();
    bus_rd_ack  = 1'b0;
    bus_rd_data = 32'h0;
    checkOutput("rd_m1_ack", m1_ack, 1'b1);
    checkOutput("rd_m1_rdata", m1_rdata, 32'h12345678);
    checkOutput("rd_m1_err", m1_err, 1'b0);
    checkOutput("rd_m0_ack", m0_ack, 1'b0);
    checkOutput("rd_m0_rdata", m0_rdata, 32'h0);
    applyStimulus(1, 0, 0, 32'h204, 32'h11111111, 4'h3);
    tick();
    checkIdleOutputs("rd_after_done");
    checkOutput("rd_rdata_hold", m1_rdata, 32'h12345678);

    // Stray read response while idle is ignored
    bus_rd_ack  = 1'b1;
    bus_rd_data = 32'hCAFEF00D;
    tick();
    bus_rd_ack  = 1'b0;
    bus_rd_data = 32'h0;
    checkIdleOutputs("idle_stray_ack");
    checkOutput("idle_stray_rdata", m1_rdata, 32'h12345678);

    // Contention from reset: m0, m1, m0, m1
    bus_reset_l = 1'b0;
    tick();
    bus_reset_l = 1'b1;
    applyStimulus(0, 1, 1, 32'h10, 32'hAAAA0000, 4'hF);
    applyStimulus(1, 1, 1, 32'h20, 32'hBBBB0000, 4'h3);
    for (int i = 0; i < 4; i++) begin
      exp_m = (i % 2) == 1;
      tick();
      checkOutput("cont_wr_req", bus_wr_req, 1'b1);
      checkOutput("cont_addr", bus_addr, exp_m ? 32'h20 : 32'h10);
      checkOutput("cont_wdata", bus_wr_data, exp_m ? 32'hBBBB0000 : 32'hAAAA0000);
      // m0 withdraws mid-write on its second grant; the write must still complete
      if (i == 2) applyStimulus(0, 0, 1, 32'h10, 32'hAAAA0000, 4'hF);
      tick();
      checkOutput("cont_m0_ack", m0_ack, !exp_m);
      checkOutput("cont_m1_ack", m1_ack, exp_m);
      checkOutput("cont_strobe_off", bus_wr_req, 1'b0);
      if (i == 3) applyStimulus(1, 0, 1, 32'h20, 32'hBBBB0000, 4'h3);
      tick();
      checkIdleOutputs("cont_idle");
    end
    tick();
    checkIdleOutputs("cont_quiet");

    // Read timeout on m0 (TIMEOUT=4)
    applyStimulus(0, 1, 0, 32'h300, 32'h0, 4'hF);
    tick();
    checkOutput("to_strobe", bus_rd_req, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("to_wait_ack", m0_ack, 1'b0);
    end
    tick();
    checkOutput("to_m0_ack", m0_ack, 1'b1);
    checkOutput("to_m0_rdata", m0_rdata, 32'hDEADBEEF);
    checkOutput("to_m0_err", m0_err, 1'b1);
    applyStimulus(0, 0, 0, 32'h300, 32'h0, 4'hF);
    bus_rd_ack  = 1'b1;
    bus_rd_data = 32'h55555555;
    tick();
    checkIdleOutputs("to_late_ack");
    checkOutput("to_late_rdata", m0_rdata, 32'hDEADBEEF);
    bus_rd_ack  = 1'b0;
    bus_rd_data = 32'h0;
    tick();
    checkOutput("to_rdata_hold", m0_rdata, 32'hDEADBEEF);

    // Reset in RD_WAIT with both requesters pending afterwards
    applyStimulus(0, 1, 0, 32'h500, 32'h0, 4'h5);
    tick();
    checkOutput("rr_strobe", bus_rd_req, 1'b1);
    tick();
    tick();
    applyStimulus(1, 1, 1, 32'h600, 32'h66666666, 4'h6);
    bus_reset_l = 1'b0;
    #1;
    checkIdleOutputs("rr_async");
    checkOutput("rr_addr", bus_addr, 32'h0);
    checkOutput("rr_be", bus_be, 4'h0);
    checkOutput("rr_m0_rdata", m0_rdata, 32'h0);
    checkOutput("rr_m0_err", m0_err, 1'b0);
    tick();
    checkIdleOutputs("rr_held");
    bus_reset_l = 1'b1;
    #1;
    checkIdleOutputs("rr_release");
    tick();
    checkOutput("rr_regrant_rd", bus_rd_req, 1'b1);
    checkOutput("rr_regrant_addr", bus_addr, 32'h500);
    bus_rd_ack  = 1'b1;
    bus_rd_data = 32'h0BADF00D;
    tick();
    bus_rd_ack  = 1'b0;
    bus_rd_data = 32'h0;
    checkOutput("rr_m0_ack", m0_ack, 1'b1);
    checkOutput("rr_m0_rdata_new", m0_rdata, 32'h0BADF00D);
    checkOutput("rr_m0_err_new", m0_err, 1'b0);
    applyStimulus(0, 0, 0, 32'h500, 32'h0, 4'h5);
    tick();
    tick();
    checkOutput("rr_m1_wr", bus_wr_req, 1'b1);
    checkOutput("rr_m1_addr", bus_addr, 32'h600);
    tick();
    checkOutput("rr_m1_ack", m1_ack, 1'b1);
    applyStimulus(1, 0, 1, 32'h600, 32'h66666666, 4'h6);
    tick();
    tick();
    checkIdleOutputs("end_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
